mul3_prod_accum: RTL and testbench

//  Downstream consumer of the 3x3 unsigned array multiplier. It accepts a stream
//  of 6-bit products over a valid/ready handshake and sums exactly N_TERMS of them
//  (a dot-product / MAC reduction). The sum is presented on a registered output

---
 rtl/mul3_prod_accum.sv | 109 ++++++++++
 tb/tb_mul3_prod_accum.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul3_prod_accum.sv
// ============================================================================
// Module      : mul3_prod_accum
// Description : Sums N_TERMS unsigned 6-bit products received over a
//               valid/ready handshake and presents the saturated total with
//               a sticky overflow flag on a registered result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul3_prod_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [ACC_W-1:0] c_ACC_MAX = {ACC_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic             ovf_q,   ovf_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [ACC_W:0]   sum_w;

    // One extra bit of headroom exposes the carry used to detect saturation.
    assign sum_w = {1'b0, acc_q} + {{(ACC_W + 1 - 6){1'b0}}, prod_in};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            c_ACCUM: begin
                if (prod_valid) begin
                    if (sum_w[ACC_W]) begin
                        acc_d = c_ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_w[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + c_CNT_ONE;
                    if (cnt_q == c_LAST) begin
                        state_d = c_DONE;
                    end
                end
            end
            c_DONE: begin
                if (acc_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode straight from the state register, so they are
    // glitch-free and carry no combinational path from the inputs.
    assign prod_ready = (state_q == c_ACCUM);
    assign acc_valid  = (state_q == c_DONE);
    assign busy       = (state_q != c_IDLE);
    assign acc_out    = acc_q;
    assign ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mul3_prod_accum.sv
// Bench for mul3_prod_accum: three configurations share one stimulus stream and
// are checked every cycle against a spec-level model plus literal expectations.
`default_nettype none

module tb_mul3_prod_accum;

    localparam int NI = 3;
    localparam int NT [NI] = '{4, 4, 1};
    localparam int AW [NI] = '{8, 7, 8};

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] prod_in;
    logic       prod_valid;
    logic       acc_ready;

    logic [7:0] acc_nom;
    logic [6:0] acc_sat;
    logic [7:0] acc_one;
    logic [2:0] a_rdy, a_vld, a_ovf, a_busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 = idle, 1 = collecting terms, 2 = result pending
    int  m_mode [NI];
    int  m_sum  [NI];
    int  m_cnt  [NI];
    int  m_ovf  [NI];
    bit  m_init = 1'b0;

    always #5 clk = ~clk;

    mul3_prod_accum #(.N_TERMS(4), .ACC_W(8)) u_nom (
        .clk(clk), .rst(rst), .start(start), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(a_rdy[0]), .acc_out(acc_nom),
        .acc_valid(a_vld[0]), .acc_ready(acc_ready), .ovf(a_ovf[0]), .busy(a_busy[0])
    );

    mul3_prod_accum #(.N_TERMS(4), .ACC_W(7)) u_sat (
        .clk(clk), .rst(rst), .start(start), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(a_rdy[1]), .acc_out(acc_sat),
        .acc_valid(a_vld[1]), .acc_ready(acc_ready), .ovf(a_ovf[1]), .busy(a_busy[1])
    );

    mul3_prod_accum #(.N_TERMS(1), .ACC_W(8)) u_one (
        .clk(clk), .rst(rst), .start(start), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(a_rdy[2]), .acc_out(acc_one),
        .acc_valid(a_vld[2]), .acc_ready(acc_ready), .ovf(a_ovf[2]), .busy(a_busy[2])
    );

    function automatic int acc_of(input int i);
        case (i)
            0:       return int'(acc_nom);
            1:       return int'(acc_sat);
            default: return int'(acc_one);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Literal expectation: pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string name, input int i, input int exp_acc,
                       input int exp_vld, input int exp_ovf);
        chk($sformatf("%s.acc[%0d]", name, i), acc_of(i), exp_acc);
        chk($sformatf("%s.model_acc[%0d]", name, i), m_sum[i], exp_acc);
        chk($sformatf("%s.valid[%0d]", name, i), int'(a_vld[i]), exp_vld);
        chk($sformatf("%s.ovf[%0d]", name, i), int'(a_ovf[i]), exp_ovf);
    endtask

    // Compare DUT against model (state after the last edge), then advance the
    // model with the inputs the next edge will sample.
    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("cyc.acc[%0d]", i), acc_of(i), m_sum[i]);
                chk($sformatf("cyc.ovf[%0d]", i), int'(a_ovf[i]), m_ovf[i]);
                chk($sformatf("cyc.ready[%0d]", i), int'(a_rdy[i]), int'(m_mode[i] == 1));
                chk($sformatf("cyc.valid[%0d]", i), int'(a_vld[i]), int'(m_mode[i] == 2));
                chk($sformatf("cyc.busy[%0d]", i), int'(a_busy[i]), int'(m_mode[i] != 0));
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (start) begin
                    m_mode[i] = 1; m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
                end
            end else if (m_mode[i] == 1) begin
                if (prod_valid) begin
                    int s;
                    int mx;
                    mx = (1 << AW[i]) - 1;
                    s  = m_sum[i] + int'(prod_in);
                    if (s > mx) begin
                        s = mx;
                        m_ovf[i] = 1;
                    end
                    m_sum[i] = s;
                    m_cnt[i]++;
                    if (m_cnt[i] == NT[i]) m_mode[i] = 2;
                end
            end else if (acc_ready) begin
                m_mode[i] = 0;
            end
        end
        if (rst) m_init = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        start      = 1'($urandom);
        prod_valid = 1'($urandom);
        acc_ready  = 1'($urandom);
        prod_in    = 6'($urandom);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        rand_inputs();
        cyc();
        rand_inputs();
        cyc();
        rst = 1'b0; start = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0; prod_in = '0;
    endtask

    task automatic feed(input int p);
        prod_valid = 1'b1;
        prod_in    = 6'(p);
        cyc();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prod_valid = 1'b0; acc_ready = 1'b0; prod_in = '0;

        // Reset with random inputs
        reset_all();
        for (int i = 0; i < NI; i++) begin
            lit("reset", i, 0, 0, 0);
            chk($sformatf("reset.ready[%0d]", i), int'(a_rdy[i]), 0);
            chk($sformatf("reset.busy[%0d]", i), int'(a_busy[i]), 0);
        end

        // Nominal: four back-to-back 49s
        start = 1'b1; cyc(); start = 1'b0;
        feed(49); feed(49); feed(49);
        chk("nom.valid_early", int'(a_vld[0]), 0);
        feed(49);
        prod_valid = 1'b0;
        lit("nom", 0, 196, 1, 0);
        lit("nom", 1, 127, 1, 1);
        lit("nom", 2, 49, 1, 0);
        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        chk("nom.busy_after", int'(a_busy[0]), 0);

        // Saturation, then the next start clears ovf
        reset_all();
        start = 1'b1; cyc(); start = 1'b0;
        feed(49); feed(49); feed(49); feed(1);
        prod_valid = 1'b0;
        lit("sat", 1, 127, 1, 1);
        lit("sat", 0, 148, 1, 0);
        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        lit("sat_idle", 1, 127, 0, 1);
        start = 1'b1; cyc(); start = 1'b0;
        lit("sat_restart", 1, 0, 0, 0);

        // Gaps and backpressure
        reset_all();
        start = 1'b1; cyc(); start = 1'b0;
        feed(3);
        prod_valid = 1'b0; prod_in = 6'd63; cyc();
        prod_in = 6'd17; cyc();
        feed(4);
        prod_valid = 1'b0; prod_in = 6'd40; cyc();
        feed(5); feed(6);
        prod_valid = 1'b0;
        lit("gap", 0, 18, 1, 0);
        lit("gap", 2, 3, 1, 0);
        for (int k = 0; k < 5; k++) begin
            start = 1'(k);
            cyc();
            lit($sformatf("hold%0d", k), 0, 18, 1, 0);
        end
        start = 1'b0; acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        chk("gap.busy_after", int'(a_busy[0]), 0);

        // Reset in the middle of an accumulation
        reset_all();
        start = 1'b1; cyc(); start = 1'b0;
        feed(9); feed(9);
        prod_valid = 1'b0;
        chk("mid.partial", int'(acc_nom), 18);
        rst = 1'b1; cyc(); rst = 1'b0;
        lit("mid_rst", 0, 0, 0, 0);
        chk("mid_rst.busy", int'(a_busy[0]), 0);
        start = 1'b1; cyc(); start = 1'b0;
        feed(1); feed(2); feed(3); feed(4);
        prod_valid = 1'b0;
        lit("mid_new", 0, 10, 1, 0);

        // Single-term configuration; start during the releasing DONE cycle
        reset_all();
        start = 1'b1; cyc(); start = 1'b0;
        feed(36);
        prod_valid = 1'b0;
        lit("one", 2, 36, 1, 0);
        acc_ready = 1'b1; start = 1'b1; cyc();
        acc_ready = 1'b0; start = 1'b0;
        lit("one_rel", 2, 36, 0, 0);
        chk("one_rel.busy", int'(a_busy[2]), 0);
        cyc();
        chk("one_idle.busy", int'(a_busy[2]), 0);
        chk("one_idle.ready", int'(a_rdy[2]), 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
